// File: rtl/sensor_conditioner_if.sv
// Signal bundle for the sensor conditioner: raw sensor lines, temperature
// feed and the conditioned outputs. clk/Rst stay outside as plain ports.
interface sensor_conditioner_if;
    logic       raw_fd;
    logic       raw_rd;
    logic       raw_win;
    logic       raw_fire;
    logic [7:0] temp_raw;
    logic       temp_vld;
    logic       SFD;
    logic       SRD;
    logic       SW;
    logic       SFA;
    logic [7:0] ST;
    logic       temp_stale;

    // Driver side: supplies sensor inputs, observes conditioned outputs
    modport master (
        output raw_fd, raw_rd, raw_win, raw_fire, temp_raw, temp_vld,
        input  SFD, SRD, SW, SFA, ST, temp_stale
    );

    // Conditioner side
    modport slave (
        input  raw_fd, raw_rd, raw_win, raw_fire, temp_raw, temp_vld,
        output SFD, SRD, SW, SFA, ST, temp_stale
    );
endinterface

// File: rtl/sensor_conditioner.sv
// Sensor conditioner: synchronizes and debounces four binary sensors and
// produces a 4-sample moving average of the temperature feed with a
// staleness watchdog that falls back to a safe substitute value.
module sensor_conditioner #(
    parameter int         DEB_CYCLES   = 4,
    parameter int         TEMP_TIMEOUT = 1000,
    parameter logic [7:0] TEMP_SAFE    = 8'd60
) (
    input logic           clk,
    input logic           Rst,
    sensor_conditioner_if.slave bus
);

    localparam int             CW      = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  DEB_MAX = CW'(DEB_CYCLES);
    localparam logic [15:0]    TO_MAX  = 16'(TEMP_TIMEOUT);

    // Channel order: 0 front door, 1 rear door, 2 window, 3 fire
    logic [3:0]    raw_vec;
    logic [3:0]    sync_a;
    logic [3:0]    sync_b;
    logic [3:0]    deb_out;
    logic [CW-1:0] deb_cnt [4];

    logic [7:0]    sample_mem [4];
    logic [1:0]    wr_ptr;
    logic [9:0]    sum;
    logic [2:0]    fill;
    logic [15:0]   to_cnt;
    logic          stale;
    logic [7:0]    st_q;

    assign raw_vec = {bus.raw_fire, bus.raw_win, bus.raw_rd, bus.raw_fd};

    // Two-flop synchronizer for the asynchronous sensor lines
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; blocking here would collapse the chain.
        if (!Rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw_vec;
            sync_b <= sync_a;
        end
    end

    // Per-channel debounce: output follows only after DEB_CYCLES+1 stable cycles
    always_ff @(posedge clk) begin
        if (!Rst) begin
            deb_out <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] == deb_out[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    deb_out[i] <= sync_b[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Sample ring, running sum, fill level and staleness watchdog
    always_ff @(posedge clk) begin
        if (!Rst) begin
            // NOTE: the ring is reset along with the sum because the sum is
            // maintained incrementally (sum - old + new); leftover entries
            // would otherwise skew the first averages after reset.
            for (int i = 0; i < 4; i++) sample_mem[i] <= '0;
            wr_ptr <= '0;
            sum    <= '0;
            fill   <= '0;
            to_cnt <= '0;
            stale  <= 1'b0;
        end else if (bus.temp_vld) begin
            // A fresh sample wins over a timeout expiring on the same cycle
            sample_mem[wr_ptr] <= bus.temp_raw;
            sum    <= sum - {2'b00, sample_mem[wr_ptr]} + {2'b00, bus.temp_raw};
            wr_ptr <= wr_ptr + 2'd1;
            if (fill != 3'd4) fill <= fill + 3'd1;
            to_cnt <= '0;
            stale  <= 1'b0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 16'd1;
            if (to_cnt + 16'd1 == TO_MAX) begin
                stale <= 1'b1;
                fill  <= '0;
            end
        end
    end

    // Averaged output: substitute value until the ring holds 4 fresh samples
    always_ff @(posedge clk) begin
        if (!Rst) begin
            st_q <= TEMP_SAFE;
        end else if (fill == 3'd4 && !stale) begin
            st_q <= sum[9:2];
        end else begin
            st_q <= TEMP_SAFE;
        end
    end

    assign bus.SFD        = deb_out[0];
    assign bus.SRD        = deb_out[1];
    assign bus.SW         = deb_out[2];
    assign bus.SFA        = deb_out[3];
    assign bus.ST         = st_q;
    assign bus.temp_stale = stale;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: stimulus queues expected output
// values tagged with the cycle they must appear; a negedge monitor compares.
module tb_sensor_conditioner;

    typedef enum int {O_FD, O_RD, O_WIN, O_FIRE, O_ST, O_STALE} sel_e;

    typedef struct {
        int         due;
        string      name;
        sel_e       sel;
        logic [7:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic Rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   flush = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] mon_act;

    sensor_conditioner_if bus ();

    sensor_conditioner #(
        .DEB_CYCLES  (4),
        .TEMP_TIMEOUT(10),
        .TEMP_SAFE   (8'd60)
    ) dut (
        .clk(clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Cycle index: number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pick(sel_e sel);
        case (sel)
            O_FD:    return {7'b0, bus.SFD};
            O_RD:    return {7'b0, bus.SRD};
            O_WIN:   return {7'b0, bus.SW};
            O_FIRE:  return {7'b0, bus.SFA};
            O_ST:    return bus.ST;
            default: return {7'b0, bus.temp_stale};
        endcase
    endfunction

    // Queue an expectation, kept sorted by due cycle
    task automatic expect_at(input int due, input string nm, input sel_e sel, input int v);
        exp_t e;
        int   i;
        e.due  = due;
        e.name = nm;
        e.sel  = sel;
        e.val  = 8'(v);
        i = sb.size();
        while (i > 0 && sb[i-1].due > due) i--;
        sb.insert(i, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due after the most recent rising edge
    always @(negedge clk) begin
        while (sb.size() > 0 && (flush || sb[0].due <= cyc)) begin
            mon_e   = sb.pop_front();
            mon_act = pick(mon_e.sel);
            n_checks = n_checks + 1;
            if (flush) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: never checked (due cycle %0d), want %0d",
                         mon_e.name, mon_e.due, mon_e.val);
            end else if (mon_act !== mon_e.val || mon_e.due != cyc) begin
                n_fail = n_fail + 1;
                $display("FAIL %s @cycle %0d (due %0d): got %0d, want %0d",
                         mon_e.name, cyc, mon_e.due, mon_act, mon_e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        Rst          = 1'b0;
        bus.raw_fd   = 1'b0;
        bus.raw_rd   = 1'b0;
        bus.raw_win  = 1'b0;
        bus.raw_fire = 1'b0;
        bus.temp_raw = 8'd0;
        bus.temp_vld = 1'b0;

        // Reset state
        step(2);
        c = cyc;
        expect_at(c, "rst_sfd",   O_FD,    0);
        expect_at(c, "rst_srd",   O_RD,    0);
        expect_at(c, "rst_sw",    O_WIN,   0);
        expect_at(c, "rst_sfa",   O_FIRE,  0);
        expect_at(c, "rst_st",    O_ST,    60);
        expect_at(c, "rst_stale", O_STALE, 0);
        Rst = 1'b1;

        // Front door 0->1: first sampling edge c+1, output at c+7
        step(1);
        c = cyc;
        bus.raw_fd = 1'b1;
        expect_at(c + 1, "fd_hold0", O_FD, 0);
        expect_at(c + 6, "fd_early", O_FD, 0);
        expect_at(c + 7, "fd_rise",  O_FD, 1);
        step(8);

        // Rear door and fire together, rise then fall
        c = cyc;
        bus.raw_rd   = 1'b1;
        bus.raw_fire = 1'b1;
        expect_at(c + 6, "rd_early",  O_RD,   0);
        expect_at(c + 6, "fa_early",  O_FIRE, 0);
        expect_at(c + 7, "rd_rise",   O_RD,   1);
        expect_at(c + 7, "fa_rise",   O_FIRE, 1);
        step(8);
        c = cyc;
        bus.raw_rd   = 1'b0;
        bus.raw_fire = 1'b0;
        expect_at(c + 6, "rd_hold1",  O_RD,   1);
        expect_at(c + 6, "fa_hold1",  O_FIRE, 1);
        expect_at(c + 7, "rd_fall",   O_RD,   0);
        expect_at(c + 7, "fa_fall",   O_FIRE, 0);
        step(8);

        // Window glitch of 3 cycles must be rejected
        c = cyc;
        bus.raw_win = 1'b1;
        for (int k = 1; k <= 12; k++) expect_at(c + k, "win_glitch", O_WIN, 0);
        step(3);
        bus.raw_win = 1'b0;
        step(10);

        // Average: 40,44,48,52 -> 46 ; then 80 -> 56 ; then timeout -> stale
        c = cyc;
        expect_at(c + 3,  "avg_fill3",   O_ST,    60);
        expect_at(c + 4,  "avg_fill4",   O_ST,    60);
        expect_at(c + 5,  "avg_46",      O_ST,    46);
        expect_at(c + 6,  "avg_46_hold", O_ST,    46);
        expect_at(c + 7,  "avg_56",      O_ST,    56);
        expect_at(c + 15, "stale_pre",   O_STALE, 0);
        expect_at(c + 16, "stale_set",   O_STALE, 1);
        expect_at(c + 16, "stale_st56",  O_ST,    56);
        expect_at(c + 17, "stale_st60",  O_ST,    60);
        expect_at(c + 18, "stale_hold",  O_STALE, 1);
        expect_at(c + 19, "stale_clr",   O_STALE, 0);
        expect_at(c + 19, "fresh1_st",   O_ST,    60);
        expect_at(c + 20, "fresh1_st2",  O_ST,    60);
        expect_at(c + 21, "fresh1_st3",  O_ST,    60);
        bus.temp_vld = 1'b1;
        bus.temp_raw = 8'd40;
        step(1);
        bus.temp_raw = 8'd44;
        step(1);
        bus.temp_raw = 8'd48;
        step(1);
        bus.temp_raw = 8'd52;
        step(1);
        bus.temp_vld = 1'b0;
        step(1);
        bus.temp_vld = 1'b1;
        bus.temp_raw = 8'd80;
        step(1);
        bus.temp_vld = 1'b0;
        step(12);
        bus.temp_vld = 1'b1;
        bus.temp_raw = 8'd90;
        step(1);
        bus.temp_vld = 1'b0;

        // Sample arriving exactly when the timeout would expire wins
        c = cyc;
        expect_at(c + 9,  "prio_pre",   O_STALE, 0);
        expect_at(c + 10, "prio_edge",  O_STALE, 0);
        expect_at(c + 11, "prio_after", O_STALE, 0);
        step(9);
        bus.temp_vld = 1'b1;
        bus.temp_raw = 8'd70;
        step(1);
        bus.temp_vld = 1'b0;

        // Let the feed go stale again so the fill count restarts at 0
        step(12);

        // Reset mid-debounce (SFA count 3) and mid-fill (fill 2)
        c = cyc;
        bus.raw_fire = 1'b1;
        expect_at(c + 5,  "pre_rst_sfd", O_FD,    1);
        expect_at(c + 6,  "mid_rst_sfd", O_FD,    0);
        expect_at(c + 6,  "mid_rst_srd", O_RD,    0);
        expect_at(c + 6,  "mid_rst_sw",  O_WIN,   0);
        expect_at(c + 6,  "mid_rst_sfa", O_FIRE,  0);
        expect_at(c + 6,  "mid_rst_st",  O_ST,    60);
        expect_at(c + 6,  "mid_rst_stl", O_STALE, 0);
        expect_at(c + 10, "post_rst_fill3", O_ST, 60);
        expect_at(c + 11, "post_rst_avg",   O_ST, 100);
        expect_at(c + 12, "post_rst_sfa0",  O_FIRE, 0);
        expect_at(c + 12, "post_rst_sfd0",  O_FD,   0);
        expect_at(c + 13, "post_rst_sfa1",  O_FIRE, 1);
        expect_at(c + 13, "post_rst_sfd1",  O_FD,   1);
        step(3);
        bus.temp_vld = 1'b1;
        bus.temp_raw = 8'd10;
        step(1);
        bus.temp_raw = 8'd20;
        step(1);
        bus.temp_vld = 1'b0;
        Rst = 1'b0;
        step(1);
        Rst = 1'b1;
        bus.temp_vld = 1'b1;
        bus.temp_raw = 8'd100;
        step(4);
        bus.temp_vld = 1'b0;
        step(10);

        // Anything still queued was never reached
        flush = 1'b1;
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable cycles required before a debounced door/window/fire output changes; legal range 2..255.
REQ-002 Parameter TEMP_TIMEOUT, default 1000: cycles without temp_vld before the temperature feed is declared stale; legal range 2..65535.
REQ-003 Parameter TEMP_SAFE, default 60: substitute ST value, inside the idle band 50..70.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Rst  input  1  reset, synchronous and active-low.
REQ-006 raw_fd  input  1  raw front-door sensor, asynchronous to clk.
REQ-007 raw_rd  input  1  raw rear-door sensor, asynchronous to clk.
REQ-008 raw_win  input  1  raw window sensor, asynchronous to clk.
REQ-009 raw_fire  input  1  raw fire sensor, asynchronous to clk.
REQ-010 temp_raw  input  8  unsigned temperature sample, qualified by temp_vld.
REQ-011 temp_vld  input  1  one-cycle strobe marking temp_raw as valid.
REQ-012 SFD  output  1  debounced front door, registered.
REQ-013 SRD  output  1  debounced rear door, registered.
REQ-014 SW  output  1  debounced window, registered.
REQ-015 SFA  output  1  debounced fire, registered.
REQ-016 ST  output  8  averaged temperature, registered.
REQ-017 temp_stale  output  1  high while the temperature feed is timed out, registered.

Function
REQ-018 Each raw_* input SHALL pass through a two-flop synchronizer before any use.
REQ-019 Each binary channel SHALL hold a counter of ceil(log2(DEB_CYCLES+1)) bits.
- Counter increments while the synchronized value differs from the channel output.
- Counter clears to 0 on any cycle where the synchronized value equals the output.
REQ-020 When the counter reaches DEB_CYCLES, the channel output SHALL take the synchronized value and the counter SHALL clear, both on the same edge.
- Latency from the first clock edge that samples a stable new raw value to the output change is exactly DEB_CYCLES+2 cycles.
REQ-021 A raw glitch shorter than DEB_CYCLES cycles, after synchronization, SHALL leave the output unchanged.
REQ-022 The four channels SHALL be independent; simultaneous changes on several channels SHALL update them on the same edge.
REQ-023 Temperature averaging SHALL use a 4-entry sample buffer, a 2-bit write pointer that wraps 3->0, a 10-bit running sum and a 3-bit fill count that saturates at 4.
REQ-024 On each temp_vld:
- The oldest entry is replaced with temp_raw.
- The sum is updated to sum - old + new.
- The pointer advances.
- All updates occur on the same edge.
REQ-025 While fill count < 4, ST SHALL equal TEMP_SAFE.
REQ-026 Once fill count = 4, ST SHALL equal sum[9:2], truncated, updated one cycle after the temp_vld edge that changed the sum.
REQ-027 temp_vld held high on consecutive cycles SHALL be accepted as one sample per cycle.
REQ-028 A 16-bit timeout counter SHALL clear on temp_vld and otherwise increment, saturating at TEMP_TIMEOUT.
REQ-029 When the timeout counter reaches TEMP_TIMEOUT:
- temp_stale is set.
- ST is forced to TEMP_SAFE.
- The fill count clears to 0.
REQ-030 temp_stale SHALL clear on the next temp_vld.
- ST remains TEMP_SAFE until 4 fresh samples have been accepted.
REQ-031 A temp_vld arriving on the same cycle the timeout would expire SHALL take priority; no stale condition occurs.

Reset
REQ-032 While Rst=0 at a clock edge, the following SHALL be set:
- SFD=SRD=SW=SFA=0.
- ST=TEMP_SAFE.
- temp_stale=0.
- All counters, synchronizer flops, pointer, sum, fill count and buffer entries = 0.
REQ-033 Reset asserted mid-debounce or mid-fill SHALL discard all partial progress.
- After release, behaviour is identical to power-up.

Verification
REQ-034 Debounce: DEB_CYCLES=4; raw_fd 0->1 held -> SFD=1 exactly 6 cycles after the first sampling edge.
REQ-035 Glitch: raw_win high for 3 cycles, then low -> SW stays 0 throughout.
REQ-036 Average: temp_vld samples 40, 44, 48, 52 -> ST=60 until the 4th sample, then ST=46 one cycle later.
- A 5th sample of 80 -> ST=56 (sum 224, shifted right by 2).
REQ-037 Stale: TEMP_TIMEOUT=10, no temp_vld for 10 cycles -> temp_stale=1 and ST=60.
- A following single sample of 90 -> temp_stale=0 and ST stays 60.
REQ-038 Reset mid-operation: Rst=0 for 1 cycle while the SFA debounce count is 3 and fill count is 2 -> all outputs at reset values.
- After release, raw_fire needs the full 6 cycles to assert SFA.
